// File: rtl/bank_counter_readout.sv
// bank_counter_readout: streams latched bank counters one per beat over valid/ready, then pulses buffer clear.
// Optional BANK_RDOUT_ZERO_SKIP_EN suppresses zero counters (except the final index).
module bank_counter_readout #(
  parameter int N_S = 32,
  parameter int N_C = 32,
  parameter int BCP = 8,
  localparam int N = N_S * N_C,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RD_Start,
  input  logic [N*BCP-1:0]      BANK_CTR_LATCHED,
  input  logic                  RD_Ready,
  output logic                  RD_Valid,
  output logic signed [BCP-1:0] RD_Data,
  output logic [IDX_W-1:0]      RD_Index,
  output logic                  RD_Slice_Last,
  output logic                  RD_Last,
  output logic                  RD_Busy,
  output logic                  RD_Err,
  output logic                  BnkCtr_Buffer_Clr,
  output logic                  RD_Done
);
  typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic signed [BCP-1:0] cur;
  logic at_last, skip, err;
  assign cur = BANK_CTR_LATCHED[idx*BCP +: BCP];
  assign at_last = idx == LAST;
`ifdef BANK_RDOUT_ZERO_SKIP_EN
  // zero counters burn one cycle each without a beat; the final index is always emitted
  assign skip = state == STREAM && cur == '0 && !at_last;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      IDLE: if (RD_Start) begin
        state_nx = STREAM;
        idx_nx = '0;
      end
      STREAM: if (skip) idx_nx = idx + 1'b1;
        else if (RD_Ready) begin
          if (at_last) state_nx = CLEAR;
          else idx_nx = idx + 1'b1;
        end
      CLEAR: begin
        state_nx = IDLE;
        idx_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      err <= RD_Start && state != IDLE;
    end
  end
  assign RD_Valid = state == STREAM && !skip;
  assign RD_Data = state == STREAM ? cur : '0;
  assign RD_Index = state == STREAM ? idx : '0;
  assign RD_Last = RD_Valid && at_last;
  assign RD_Slice_Last = RD_Valid && (int'(idx) % N_C) == N_C - 1;
  assign RD_Busy = state != IDLE;
  assign RD_Err = err;
  assign BnkCtr_Buffer_Clr = state == CLEAR;
  assign RD_Done = state == CLEAR;
endmodule
